// File: rtl/serial_bit_scanner_if.sv
// Mux-select / serial-link bundle between the bit scanner, the 32:1 mux and the display.
interface serial_bit_scanner_if;
    logic       Start;
    logic       MuxOut;
    logic [4:0] Sel;
    logic       MuxEnable;
    logic       SerData;
    logic       SerClk;
    logic       SerLatch;
    logic       Busy;
    logic       Done;

    // Scanner side: drives the mux select and the serial link.
    modport master (
        input  Start,
        input  MuxOut,
        output Sel,
        output MuxEnable,
        output SerData,
        output SerClk,
        output SerLatch,
        output Busy,
        output Done
    );

    // Environment side: requests transactions, returns the mux bit, observes the link.
    modport slave (
        output Start,
        output MuxOut,
        input  Sel,
        input  MuxEnable,
        input  SerData,
        input  SerClk,
        input  SerLatch,
        input  Busy,
        input  Done
    );
endinterface

// File: rtl/serial_bit_scanner.sv
// Walks the 32:1 mux select, serialises the returned bit onto SerData with a
// divided SerClk, and strobes SerLatch once the whole word has been shifted.
module serial_bit_scanner #(
    parameter int unsigned BIT_COUNT = 32,
    parameter int unsigned CLK_DIV   = 2,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                 GlobalClock,
    input  logic                 Reset_n,
    serial_bit_scanner_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOW   = 2'd1,
        HIGH  = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(BIT_COUNT - 1);
    localparam logic [4:0] IDLE_SEL = MSB_FIRST ? LAST_IDX : 5'd0;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_q,    state_d;
    logic [7:0] div_cnt_q,  div_cnt_d;
    logic [4:0] bit_cnt_q,  bit_cnt_d;
    logic [4:0] sel_q,      sel_d;
    logic       mux_en_q,   mux_en_d;
    logic       ser_data_q, ser_data_d;
    logic       ser_clk_q,  ser_clk_d;
    logic       latch_q,    latch_d;
    logic       busy_q,     busy_d;
    logic       done_q,     done_d;

    // Next-state and next-output computation for the bit sequencer.
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sel_d      = sel_q;
        mux_en_d   = mux_en_q;
        ser_data_d = ser_data_q;
        ser_clk_d  = ser_clk_q;
        latch_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                mux_en_d  = 1'b0;
                ser_clk_d = 1'b0;
                busy_d    = 1'b0;
                if (bus.Start) begin
                    state_d   = LOW;
                    busy_d    = 1'b1;
                    mux_en_d  = 1'b1;
                    sel_d     = IDLE_SEL;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end

            LOW: begin
                // Capture early so SerData settles CLK_DIV-1 cycles before SerClk rises.
                if (div_cnt_q == 8'd0) begin
                    ser_data_d = bus.MuxOut;
                end
                if (div_cnt_q == DIV_LAST) begin
                    state_d   = HIGH;
                    div_cnt_d = '0;
                    ser_clk_d = 1'b1;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            HIGH: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    ser_clk_d = 1'b0;
                    if (bit_cnt_q == LAST_IDX) begin
                        state_d  = LATCH;
                        mux_en_d = 1'b0;
                        latch_d  = 1'b1;
                    end else begin
                        state_d   = LOW;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        sel_d     = MSB_FIRST ? (sel_q - 5'd1) : (sel_q + 5'd1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            LATCH: begin
                state_d   = IDLE;
                ser_clk_d = 1'b0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                sel_d     = IDLE_SEL;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything without waiting for a clock.
    always_ff @(posedge GlobalClock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            sel_q      <= '0;
            mux_en_q   <= 1'b0;
            ser_data_q <= 1'b0;
            ser_clk_q  <= 1'b0;
            latch_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sel_q      <= sel_d;
            mux_en_q   <= mux_en_d;
            ser_data_q <= ser_data_d;
            ser_clk_q  <= ser_clk_d;
            latch_q    <= latch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.Sel       = sel_q;
    assign bus.MuxEnable = mux_en_q;
    assign bus.SerData   = ser_data_q;
    assign bus.SerClk    = ser_clk_q;
    assign bus.SerLatch  = latch_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;

endmodule

// File: tb/tb_serial_bit_scanner.sv
// Directed bench: default LSB-first instance and an 8-bit MSB-first instance, each fed by a mux model.
module tb_serial_bit_scanner;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    logic [31:0] word_a = 32'hA500_0001;
    logic [31:0] word_b = 32'h0000_003C;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    serial_bit_scanner_if ifa ();
    serial_bit_scanner_if ifb ();

    assign ifa.MuxOut = ifa.MuxEnable ? word_a[ifa.Sel] : 1'b0;
    assign ifb.MuxOut = ifb.MuxEnable ? word_b[ifb.Sel] : 1'b0;

    serial_bit_scanner dut_a (
        .GlobalClock (clk),
        .Reset_n     (rst_a),
        .bus         (ifa)
    );

    serial_bit_scanner #(
        .BIT_COUNT (8),
        .CLK_DIV   (3),
        .MSB_FIRST (1'b1)
    ) dut_b (
        .GlobalClock (clk),
        .Reset_n     (rst_b),
        .bus         (ifb)
    );

    typedef struct {
        int         cyc;
        logic [4:0] sel;
        logic       en;
        logic       sclk;
        logic       data;
        logic       busy;
        logic       latch;
        logic       done;
    } vec_t;

    localparam int NV = 14;
    vec_t vt[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input int c, input logic [4:0] s, input logic e, input logic k,
                                input logic d, input logic b, input logic l, input logic dn);
        vec_t v;
        v.cyc = c; v.sel = s; v.en = e; v.sclk = k; v.data = d; v.busy = b; v.latch = l; v.done = dn;
        return v;
    endfunction

    function automatic logic [10:0] pack_a();
        return {ifa.Sel, ifa.MuxEnable, ifa.SerClk, ifa.SerData, ifa.Busy, ifa.SerLatch, ifa.Done};
    endfunction

    function automatic logic [10:0] pack_b();
        return {ifb.Sel, ifb.MuxEnable, ifb.SerClk, ifb.SerData, ifb.Busy, ifb.SerLatch, ifb.Done};
    endfunction

    initial begin
        int vi;
        int rise;
        int sel_err;
        int busy_err;
        int idle_err;
        logic prev_clk;
        logic prev_data;
        logic exp_b[8];

        //            cyc  sel  en clk dat bsy lat dn
        vt[0]  = mk(  1,   0,  1, 0,  0,  1,  0,  0);
        vt[1]  = mk(  2,   0,  1, 0,  1,  1,  0,  0);
        vt[2]  = mk(  3,   0,  1, 1,  1,  1,  0,  0);
        vt[3]  = mk(  4,   0,  1, 1,  1,  1,  0,  0);
        vt[4]  = mk(  5,   1,  1, 0,  1,  1,  0,  0);
        vt[5]  = mk(  6,   1,  1, 0,  0,  1,  0,  0);
        vt[6]  = mk( 40,   9,  1, 1,  0,  1,  0,  0);
        vt[7]  = mk( 41,  10,  1, 0,  0,  1,  0,  0);
        vt[8]  = mk(126,  31,  1, 0,  1,  1,  0,  0);
        vt[9]  = mk(127,  31,  1, 1,  1,  1,  0,  0);
        vt[10] = mk(128,  31,  1, 1,  1,  1,  0,  0);
        vt[11] = mk(129,  31,  0, 0,  1,  1,  1,  0);
        vt[12] = mk(130,   0,  0, 0,  1,  0,  0,  1);
        vt[13] = mk(131,   0,  1, 0,  1,  1,  0,  0);

        exp_b = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        ifa.Start = 1'b0;
        ifb.Start = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Reset held for 3 cycles.
        repeat (3) @(posedge clk);
        #1;
        check("reset_a_outputs", 32'(pack_a()), 32'd0);
        check("reset_b_outputs", 32'(pack_b()), 32'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        busy_err = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ifa.Busy !== 1'b0 || ifb.Busy !== 1'b0) busy_err++;
        end
        check("idle_after_reset_outputs_a", 32'(pack_a()), 32'd0);
        check("idle_no_busy_without_start", 32'(busy_err), 32'd0);

        // MSB-first, 8 bits, CLK_DIV=3.
        @(posedge clk); #1;
        ifb.Start = 1'b1;
        @(posedge clk); #1;
        ifb.Start = 1'b0;
        rise = 0; sel_err = 0; busy_err = 0;
        prev_clk = ifb.SerClk; prev_data = ifb.SerData;
        for (int n = 1; n <= 51; n++) begin
            @(negedge clk);
            if (n <= 48 && ifb.Sel !== 5'(7 - (n - 1) / 6)) sel_err++;
            if (n <= 49 && ifb.Busy !== 1'b1) busy_err++;
            if (prev_clk === 1'b0 && ifb.SerClk === 1'b1) begin
                check("msb_setup", 32'(ifb.SerData), 32'(prev_data));
                if (rise < 8) check($sformatf("msb_bit%0d", rise), 32'(ifb.SerData), 32'(exp_b[rise]));
                rise++;
            end
            if (n == 48) check("msb_last_high", {30'd0, ifb.SerClk, ifb.SerLatch}, 32'b10);
            if (n == 49) check("msb_latch_cycle", {27'd0, ifb.SerLatch, ifb.Done, ifb.Busy, ifb.MuxEnable, ifb.SerClk}, 32'b10100);
            if (n == 50) check("msb_done_cycle", {24'd0, ifb.SerLatch, ifb.Done, ifb.Busy, ifb.Sel}, {24'd0, 3'b010, 5'd7});
            if (n == 51) check("msb_done_one_cycle", 32'(ifb.Done), 32'd0);
            prev_clk = ifb.SerClk; prev_data = ifb.SerData;
            @(posedge clk); #1;
        end
        check("msb_sel_sequence_errors", 32'(sel_err), 32'd0);
        check("msb_busy_errors", 32'(busy_err), 32'd0);
        check("msb_rising_edges", 32'(rise), 32'd8);

        // LSB-first defaults; Start ignored at 40, accepted in Done cycle, then abort at Sel=12 HIGH.
        ifa.Start = 1'b1;
        @(posedge clk); #1;
        ifa.Start = 1'b0;
        vi = 0; rise = 0; sel_err = 0; busy_err = 0;
        prev_clk = ifa.SerClk; prev_data = ifa.SerData;
        for (int n = 1; n <= 181; n++) begin
            ifa.Start = (n == 40 || n == 130);
            @(negedge clk);
            if (vi < NV && vt[vi].cyc == n) begin
                check($sformatf("lsb_vec_cycle%0d", n), 32'(pack_a()),
                      32'({vt[vi].sel, vt[vi].en, vt[vi].sclk, vt[vi].data, vt[vi].busy, vt[vi].latch, vt[vi].done}));
                vi++;
            end
            if (n <= 128 && ifa.Sel !== 5'((n - 1) / 4)) sel_err++;
            if (n <= 129 && ifa.Busy !== 1'b1) busy_err++;
            if (prev_clk === 1'b0 && ifa.SerClk === 1'b1) begin
                check("lsb_setup", 32'(ifa.SerData), 32'(prev_data));
                if (rise < 32) check($sformatf("lsb_bit%0d", rise), 32'(ifa.SerData), 32'(word_a[rise]));
                rise++;
            end
            prev_clk = ifa.SerClk; prev_data = ifa.SerData;
            if (n == 181) begin
                check("abort_pre_sel_clk", {26'd0, ifa.Sel, ifa.SerClk}, {26'd0, 5'd12, 1'b1});
                #1 rst_a = 1'b0;
                #1;
                check("abort_async_outputs", 32'(pack_a()), 32'd0);
            end else begin
                @(posedge clk); #1;
            end
        end
        check("lsb_sel_sequence_errors", 32'(sel_err), 32'd0);
        check("lsb_busy_errors", 32'(busy_err), 32'd0);

        repeat (2) @(posedge clk);
        #1 rst_a = 1'b1;
        idle_err = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ifa.SerLatch !== 1'b0 || ifa.Done !== 1'b0 || ifa.Busy !== 1'b0 || ifa.SerClk !== 1'b0) idle_err++;
        end
        check("post_abort_quiet", 32'(idle_err), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
